// File: rtl/clk_div_prog_pkg.sv
// clk_div_pkg: shared definitions for the programmable clock divider.
//   state_t   divider FSM states (STOP, HIGH, LOW)
//   DIV_MIN   smallest divisor accepted by a load
//   high_len  high-phase length (N+1)>>1, one bit wider than N
//   low_len   low-phase length N>>1
package clk_div_pkg;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int unsigned DIV_MIN = 2;

   // Widest divisor the helpers handle; callers zero-extend into it.
   localparam int unsigned MAX_W = 32;

   // The extra result bit keeps N+1 from wrapping at the all-ones divisor.
   function automatic logic [MAX_W:0] high_len(input logic [MAX_W-1:0] n);
      return ({1'b0, n} + 1'b1) >> 1;
   endfunction

   function automatic logic [MAX_W:0] low_len(input logic [MAX_W-1:0] n);
      return {1'b0, n} >> 1;
   endfunction

endpackage

// File: rtl/clk_div_prog.sv
// clk_div_prog: run-time programmable clock divider in the CLK100MHZ domain.
// Produces a divided clock level plus single-cycle rise/fall strobes so that
// downstream serial logic can run on clock enables. Divisor reloads are
// applied only at the start of a high phase; dropping en always lets the
// current period finish.
//   CLK100MHZ   system clock, rising edge
//   CPU_RESETN  synchronous active-low reset
//   en          run request
//   div_i       new divisor, valid with div_load
//   div_load    one-cycle load request
//   clk_o       divided clock level
//   rise_stb    first cycle of each high phase
//   fall_stb    first cycle of each low phase
//   div_active  divisor currently in effect
//   load_pend   accepted divisor waiting for a boundary
//   load_err    one-cycle pulse after a rejected load (div_i < 2)
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 25
) (
   input  logic             CLK100MHZ,
   input  logic             CPU_RESETN,
   input  logic             en,
   input  logic [CNT_W-1:0] div_i,
   input  logic             div_load,
   output logic             clk_o,
   output logic             rise_stb,
   output logic             fall_stb,
   output logic [CNT_W-1:0] div_active,
   output logic             load_pend,
   output logic             load_err
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_q, clk_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] act_q, act_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_v_q, pend_v_d;
   logic             err_q, err_d;

   logic [CNT_W:0]   h_len;
   logic [CNT_W:0]   l_len;
   logic             high_done;
   logic             low_done;
   logic             load_ok;
   logic             load_bad;
   logic             boundary;

   always_comb begin
      h_len     = (CNT_W+1)'(high_len(MAX_W'(act_q)));
      l_len     = (CNT_W+1)'(low_len(MAX_W'(act_q)));
      high_done = ({1'b0, cnt_q} == (h_len - 1'b1));
      low_done  = ({1'b0, cnt_q} == (l_len - 1'b1));
      load_ok   = div_load && (div_i >= CNT_W'(DIV_MIN));
      load_bad  = div_load && !load_ok;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clk_d    = clk_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      act_d    = act_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      err_d    = load_bad;
      boundary = 1'b0;

      case (state_q)
         STOP: begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (en) begin
               state_d  = HIGH;
               clk_d    = 1'b1;
               rise_d   = 1'b1;
               boundary = 1'b1;
            end
         end
         HIGH: begin
            if (high_done) begin
               state_d = LOW;
               cnt_d   = '0;
               clk_d   = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOW: begin
            if (low_done) begin
               cnt_d = '0;
               if (en) begin
                  state_d  = HIGH;
                  clk_d    = 1'b1;
                  rise_d   = 1'b1;
                  boundary = 1'b1;
               end else begin
                  state_d = STOP;
                  clk_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = STOP;
            cnt_d   = '0;
            clk_d   = 1'b0;
         end
      endcase

      // The boundary consumes the value pending before this edge; a load on
      // the same edge is evaluated afterwards so it becomes the next pending.
      if (boundary && pend_v_q) begin
         act_d    = pend_q;
         pend_v_d = 1'b0;
      end

      if (load_ok) begin
         if (state_q == STOP && !en) begin
            act_d    = div_i;
            pend_v_d = 1'b0;
         end else begin
            pend_d   = div_i;
            pend_v_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         state_q  <= STOP;
         cnt_q    <= '0;
         clk_q    <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         act_q    <= DIV_RST;
         pend_q   <= DIV_RST;
         pend_v_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         clk_q    <= clk_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         act_q    <= act_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         err_q    <= err_d;
      end
   end

   assign clk_o      = clk_q;
   assign rise_stb   = rise_q;
   assign fall_stb   = fall_q;
   assign div_active = act_q;
   assign load_pend  = pend_v_q;
   assign load_err   = err_q;

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Run-time programmable clock divider: the parametrised successor to the fixed 100 MHz→4 MHz SPI clock divider. It produces a divided clock level plus single-cycle rise/fall strobes in the CLK100MHZ domain, so SPI and other serial logic can run on clock enables instead of a derived clock. The divisor can be reloaded at run time, and the change is applied glitch-free at a period boundary. An enable stops the output cleanly, always at the end of a full period.

## Interface
- CNT_W, 16: width of divisor and internal counter.
- DEFAULT_DIV, 25: divisor in use after reset. Must be ≥2 and <2^CNT_W. The default gives 4 MHz from 100 MHz.

- CLK100MHZ  in  1  system clock; all logic on its rising edge.
- CPU_RESETN  in  1  reset, synchronous, active-low.
- en  in  1  run request; sampled every cycle.
- div_i  in  CNT_W  new divisor N, valid while div_load=1.
- div_load  in  1  one-cycle request to load div_i.
- clk_o  out  1  divided clock level. Reset 0.
- rise_stb  out  1  high for the first cycle of each high phase. Reset 0.
- fall_stb  out  1  high for the first cycle of each low phase. Reset 0.
- div_active  out  CNT_W  divisor currently in effect. Reset DEFAULT_DIV.
- load_pend  out  1  a loaded divisor is waiting for a boundary. Reset 0.
- load_err  out  1  one-cycle pulse when div_load is rejected. Reset 0.

## Operation
- Phase lengths:
  - High phase H = (N+1)>>1 cycles; low phase L = N>>1 cycles. Period = N; odd N puts the extra cycle in the high phase.
  - Compute H in CNT_W+1 bits so no overflow occurs at N = 2^CNT_W−1.
- States:
  - STOP: clk_o=0, counter=0.
  - HIGH: clk_o=1.
  - LOW: clk_o=0.
- Transitions:
  - STOP→HIGH when en=1. In the first HIGH cycle, clk_o=1 and rise_stb=1.
  - HIGH: counter runs 0..H−1. At H−1, go to LOW, reset counter to 0, and assert fall_stb on the first LOW cycle. en is ignored during HIGH.
  - LOW: counter runs 0..L−1. At L−1:
    - if en=1, go to HIGH and assert rise_stb;
    - else go to STOP.
  - The low phase always completes, so no runt pulse is ever produced.
- Divisor load:
  - div_load=1 and div_i≥2: store div_i as pending and set load_pend.
  - div_load=1 and div_i<2: assert load_err for the next cycle. Pending and active values are unchanged.
- Divisor apply:
  - A pending value becomes div_active only at a LOW→HIGH or STOP→HIGH transition, and that new period uses it. load_pend clears on the same edge.
  - In STOP with en=0, an accepted load moves to div_active on the next edge; load_pend stays 0.
- Simultaneous events:
  - Load on the same cycle as a boundary: the boundary applies the old pending value (or none). The new value is stored as pending for the following boundary.
  - Two loads before a boundary: the last one wins.
  - en falling in the same cycle as a boundary: go to STOP.
- Reset mid-operation: on the next edge every output takes its reset value and the state returns to STOP, including mid-phase. Any pending value is discarded.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- en rise to first clk_o=1: 1 cycle from STOP.
- rise_stb and fall_stb coincide with the first cycle of the new clk_o level, never both at once. Each is exactly 1 cycle wide.
- With div_active=N and en held, the rise_stb period is exactly N cycles and clk_o is high for exactly H cycles.
- Divisor change latency: the load is applied at the next start of a high phase after the load edge, so at most N_old cycles later.

## Structure
- Shared package clk_div_pkg holds:
  - state enum {STOP, HIGH, LOW};
  - constant DIV_MIN = 2;
  - helper functions for high_len(N) and low_len(N).
- Single module with no sub-module. Counter, FSM, and the pending/active register pair are all local.

## Test plan
- Reset, en=1, default N=25 → clk_o high 13 cycles and low 12; rise_stb every 25 cycles; fall_stb 13 cycles after each rise_stb.
- Running at N=25, load div_i=4 mid high phase → current period finishes at 25 cycles; load_pend=1 until the next rise; then 2 high / 2 low.
- Load div_i=1, then div_i=0 → load_err pulses each time; div_active unchanged; output period unchanged.
- Load N=7 then N=9 before the boundary; then load N=3 exactly on the LOW→HIGH cycle → next period 9 (5 high/4 low), then 3 (2/1).
- Drop en at cycle 3 of a HIGH phase with N=10 → 5 high, 5 low, then STOP with clk_o=0. Re-raise en → clk_o=1 one cycle later with rise_stb.
- Assert CPU_RESETN=0 for 1 cycle mid LOW with a pending load → all outputs at reset values; div_active=25; load_pend=0.
